// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO unit op codes, its FSM encoding and
// two's-complement helpers used for operand magnitudes and sign correction.
package mips_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes; the sign is applied when the result is written.
module mult_div_unit
    import mips_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] Operand_A,
    input  logic [XLEN-1:0] Operand_B,
    input  logic            HI_Write,
    input  logic            LO_Write,
    input  logic [XLEN-1:0] Write_Data,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    md_state_e       state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_mul_q, is_mul_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN-1:0] work_hi_q, work_hi_d;
    logic [XLEN-1:0] work_lo_q, work_lo_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            in_signed, in_mul;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   shift_in, add_x, add_y, add_res, mul_sum;
    logic            do_sub;
    logic [XLEN-1:0] step_hi, step_lo, res_hi, res_lo;
    logic [63:0]     prod, prod_neg;

    // m_q holds the multiplicand (multiply) or the divisor (divide); work_lo_q
    // starts as the multiplier / dividend and shifts out as product-low / quotient.
    always_comb begin : datapath
        in_signed = (Op == OP_MULT) || (Op == OP_DIV);
        in_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
        mag_a     = abs_val(Operand_A, in_signed);
        mag_b     = abs_val(Operand_B, in_signed);

        shift_in = {work_hi_q, work_lo_q[XLEN-1]};
        add_x    = is_mul_q ? {1'b0, work_hi_q} : shift_in;
        add_y    = {1'b0, m_q};
        do_sub   = !is_mul_q;
        add_res  = add_x + (add_y ^ {(XLEN+1){do_sub}}) + {32'd0, do_sub};

        mul_sum = work_lo_q[0] ? add_res : add_x;
        step_hi = mul_sum[XLEN:1];
        step_lo = {mul_sum[0], work_lo_q[XLEN-1:1]};
        if (!is_mul_q) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!add_res[XLEN]) begin
                step_hi = add_res[XLEN-1:0];
                step_lo = {work_lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = shift_in[XLEN-1:0];
                step_lo = {work_lo_q[XLEN-2:0], 1'b0};
            end
        end

        prod     = {step_hi, step_lo};
        prod_neg = ~prod + 64'd1;
        if (is_mul_q) begin
            {res_hi, res_lo} = neg_lo_q ? prod_neg : prod;
        end else begin
            res_lo = neg_lo_q ? neg32(step_lo) : step_lo;
            res_hi = neg_hi_q ? neg32(step_hi) : step_hi;
        end
    end

    always_comb begin : control
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mul_d  = is_mul_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        m_d       = m_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (HI_Write) hi_d = Write_Data;
                if (LO_Write) lo_d = Write_Data;
                if (Start) begin
                    state_d   = MD_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = 5'd0;
                    is_mul_d  = in_mul;
                    m_d       = in_mul ? mag_a : mag_b;
                    work_hi_d = '0;
                    work_lo_d = in_mul ? mag_b : mag_a;
                    // A zero divisor keeps the all-ones quotient unsigned-looking.
                    neg_lo_d  = in_signed && (Operand_A[XLEN-1] ^ Operand_B[XLEN-1])
                                && (in_mul || (Operand_B != '0));
                    neg_hi_d  = in_signed && !in_mul && Operand_A[XLEN-1];
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                busy_d    = 1'b1;
                cnt_d     = cnt_q + 5'd1;
                work_hi_d = step_hi;
                work_lo_d = step_lo;
                if (cnt_q == 5'd31) begin
                    state_d = MD_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= MD_IDLE;
            cnt_q     <= 5'd0;
            is_mul_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            m_q       <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mul_q  <= is_mul_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            m_q       <= m_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of hand-computed results
// plus sequences for mid-run pokes, back-to-back start and reset abort.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        HI_Write;
    logic        LO_Write;
    logic [31:0] Write_Data;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    mult_div_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Start      (Start),
        .Op         (Op),
        .Operand_A  (Operand_A),
        .Operand_B  (Operand_B),
        .HI_Write   (HI_Write),
        .LO_Write   (LO_Write),
        .Write_Data (Write_Data),
        .Busy       (Busy),
        .Done       (Done),
        .HI         (HI),
        .LO         (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge. Sample n is taken at the negedge after edge k+n-1,
    // where edge k is the one that accepts Start.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input bit chk_hold, input logic [31:0] hold_val,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output int busy_n, output bit hold_ok);
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        lat       = 0;
        busy_n    = 0;
        hold_ok   = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (Busy) busy_n++;
            if (chk_hold && !Done && HI !== hold_val) hold_ok = 1'b0;
            if (Done) begin
                lat = n;
                break;
            end
            if (n == 1 || n == poke_at + 1) begin
                Start      = 1'b0;
                HI_Write   = 1'b0;
                LO_Write   = 1'b0;
                Op         = 2'($urandom);
                Operand_A  = $urandom;
                Operand_B  = $urandom;
                Write_Data = $urandom;
            end
            if (n == poke_at) begin
                Start      = 1'b1;
                HI_Write   = 1'b1;
                LO_Write   = 1'b1;
                Write_Data = 32'hDEADBEEF;
                Operand_A  = $urandom;
                Operand_B  = $urandom;
            end
        end
        hi = HI;
        lo = LO;
    endtask

    logic [31:0] r_hi, r_lo;
    int          r_lat, r_busy;
    bit          r_hold;
    bit          seen_done;

    initial begin
        vecs = '{
            '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
            '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
            '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
            '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
            '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
            '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
            '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000},
            '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
            '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
            '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
            '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000},
            '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF},
            '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
            '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003}
        };

        RESET = 1'b1; Start = 1'b0; Op = 2'b00; Operand_A = '0; Operand_B = '0;
        HI_Write = 1'b0; LO_Write = 1'b0; Write_Data = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk32("reset busy", 32'(Busy), 32'd0);
        chk32("reset done", 32'(Done), 32'd0);
        chk32("reset hi", HI, 32'd0);
        chk32("reset lo", LO, 32'd0);
        RESET = 1'b0;

        // mthi / mtlo in IDLE
        HI_Write = 1'b1; Write_Data = 32'hAAAA5555;
        @(negedge CLK);
        HI_Write = 1'b0;
        chk32("mthi hi", HI, 32'hAAAA5555);
        chk32("mthi lo", LO, 32'd0);
        LO_Write = 1'b1; Write_Data = 32'h5555AAAA;
        @(negedge CLK);
        LO_Write = 1'b0;
        chk32("mtlo lo", LO, 32'h5555AAAA);
        chk32("mtlo hi", HI, 32'hAAAA5555);

        for (int i = 0; i < NV; i++) begin
            if (i % 3 == 0) @(negedge CLK);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, 32'd0, r_hi, r_lo, r_lat, r_busy, r_hold);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, r_hi, r_lo, r_lat);
            chk32($sformatf("v%0d hi", i), r_hi, vecs[i].hi);
            chk32($sformatf("v%0d lo", i), r_lo, vecs[i].lo);
            chk32($sformatf("v%0d latency", i), 32'(r_lat), 32'd33);
            chk32($sformatf("v%0d busy cycles", i), 32'(r_busy), 32'd32);
        end

        // Start/HI_Write/LO_Write poked mid-run must be ignored
        @(negedge CLK);
        HI_Write = 1'b1; Write_Data = 32'hCAFEBABE;
        @(negedge CLK);
        HI_Write = 1'b0;
        do_op(OP_MULT, 32'h7, 32'hFFFFFFFD, 5, 1'b1, 32'hCAFEBABE, r_hi, r_lo, r_lat, r_busy, r_hold);
        $display("poke run: hi=%h lo=%h lat=%0d", r_hi, r_lo, r_lat);
        chk32("poke hi", r_hi, 32'hFFFFFFFF);
        chk32("poke lo", r_lo, 32'hFFFFFFEB);
        chk32("poke latency", 32'(r_lat), 32'd33);
        chk32("poke hi held", 32'(r_hold), 32'd1);
        @(negedge CLK);
        chk32("poke no queued start", 32'({Busy, Done}), 32'd0);

        // Start in the Done cycle together with mthi
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0, 32'd0, r_hi, r_lo, r_lat, r_busy, r_hold);
        chk32("b2b first hi", r_hi, 32'd2);
        chk32("b2b first lo", r_lo, 32'd14);
        HI_Write = 1'b1; Write_Data = 32'h12345678;
        do_op(OP_MULTU, 32'd3, 32'd5, 0, 1'b1, 32'h12345678, r_hi, r_lo, r_lat, r_busy, r_hold);
        $display("b2b second: hi=%h lo=%h lat=%0d", r_hi, r_lo, r_lat);
        chk32("b2b hi held", 32'(r_hold), 32'd1);
        chk32("b2b hi", r_hi, 32'd0);
        chk32("b2b lo", r_lo, 32'd15);
        chk32("b2b latency", 32'(r_lat), 32'd33);

        // Reset abort at iteration 10
        HI_Write = 1'b1; LO_Write = 1'b1; Write_Data = 32'h11111111;
        @(negedge CLK);
        HI_Write = 1'b0; LO_Write = 1'b0;
        Start = 1'b1; Op = OP_MULTU; Operand_A = 32'hFFFFFFFF; Operand_B = 32'hFFFFFFFF;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            if (n == 1) Start = 1'b0;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        $display("reset abort: busy=%0b hi=%h lo=%h", Busy, HI, LO);
        chk32("abort busy", 32'(Busy), 32'd0);
        chk32("abort hi", HI, 32'd0);
        chk32("abort lo", LO, 32'd0);
        seen_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (Done) seen_done = 1'b1;
        end
        chk32("abort no done", 32'(seen_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 Start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-006 Operand_A  input  32  rs value (multiplicand or dividend); sampled with Start.
REQ-007 Operand_B  input  32  rt value (multiplier or divisor); sampled with Start.
REQ-008 HI_Write  input  1  mthi: load HI from Write_Data.
REQ-009 LO_Write  input  1  mtlo: load LO from Write_Data.
REQ-010 Write_Data  input  32  data for mthi/mtlo.
REQ-011 Busy  output  1  high while in RUN; the pipeline stalls mfhi/mflo/mult/div while it is high.
REQ-012 Done  output  1  high for exactly one cycle (DONE state), when HI/LO hold the new result.
REQ-013 HI  output  32  HI register, feeding the register-file write-data mux for mfhi.
REQ-014 LO  output  32  LO register, feeding the register-file write-data mux for mflo.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 Transitions: IDLE/DONE with Start=1 -> RUN; DONE with Start=0 -> IDLE; RUN -> DONE on the edge that completes iteration 32.
REQ-017 On Start acceptance the block SHALL latch Op, the operand magnitudes (absolute values for signed ops), the result sign flags, and clear the 5-bit iteration counter.
REQ-018 RUN SHALL perform one iteration per cycle for 32 cycles: a shift-add step for multiply, a restoring shift-subtract step (33-bit subtract) for divide.
REQ-019 On the edge RUN->DONE, HI/LO SHALL load the sign-corrected result, so that Done and the valid HI/LO appear in the same cycle.
REQ-020 Latency: Start high at edge k -> Done high during the cycle after edge k+32, and Busy high during cycles k+1 through k+32.
REQ-021 MULT/MULTU SHALL produce {HI,LO} = 64-bit product; the signed product is negated when the signs of A and B differ.
REQ-022 DIV/DIVU SHALL produce LO = quotient and HI = remainder; the quotient sign is signA^signB and the remainder takes the sign of A.
REQ-023 For a divisor of 0, the block SHALL produce HI = Operand_A and LO = 32'hFFFFFFFF in both signed and unsigned modes, with the same latency.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO = 32'h80000000 and HI = 0 (wrap, no trap).
REQ-025 HI_Write/LO_Write SHALL take effect at the next edge in IDLE or DONE and SHALL be ignored in RUN.
REQ-026 Start in RUN SHALL be ignored, with no queuing.
REQ-027 When Start and HI_Write/LO_Write occur together in IDLE/DONE, both SHALL apply; the later result overwrites HI/LO.
REQ-028 Operand, Op and Write_Data changes during RUN SHALL NOT affect the result.

Reset
REQ-029 While RESET=1 at an edge: state -> IDLE, counter -> 0, HI -> 0, LO -> 0, Busy -> 0, Done -> 0; RESET overrides Start and HI_Write/LO_Write.
REQ-030 A reset during RUN SHALL abort the operation, with no Done pulse and no partial result in HI/LO.

Structure
REQ-031 The Op encodings (MULT, MULTU, DIV, DIVU) and the state encoding SHALL live in the shared mips_pkg package.
REQ-032 The block SHALL be a single module with no sub-module; one 33-bit adder/subtractor SHALL be shared by multiply and divide.

Verification
REQ-033 MULT 32'h00000007 x 32'hFFFFFFFD -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; Done exactly 33 cycles after the Start edge; Busy high for 32 cycles.
REQ-034 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-035 DIV 32'hFFFFFFF9 / 32'h00000002 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU 7 / 0 -> HI=32'h00000007, LO=32'hFFFFFFFF.
REQ-036 DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=32'h00000000.
REQ-037 RESET asserted at iteration 10 -> next cycle Busy=0, HI=LO=0, and no Done within 40 cycles; Start and HI_Write pulsed mid-RUN -> no effect on the result or HI.
REQ-038 Start issued in the Done cycle with HI_Write=1 and Write_Data=32'h12345678 -> HI=32'h12345678 for the next 32 cycles, then overwritten by the new result; Done pulses again.
